bram_stream_reader: RTL
=======================

# bram_stream_reader

Streaming read controller sitting directly upstream of an `alta_bram` configured as ROM (write-enable tied low). It replaces a free-running counter on the address pins: it generates a bounded or looping address sequence on one BRAM port and absorbs the BRAM's one-cycle registered read latency. Results go out as a valid/ready stream, so downstream consumers (LED drivers, serializers) can apply backpressure without losing words.

## Interface
- `ADDR_W`, 10: BRAM port address width.
- `DATA_W`, 4: BRAM port data width.
- `PACE_W`, 16: width of pacing divider.
- `clk`  in  1: single clock; also drives the BRAM port clock.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: one-cycle pulse; latches `base_addr`, `last_off`, `loop_en`; ignored while `busy`.
- `base_addr`  in  ADDR_W: first address read.
- `last_off`  in  ADDR_W: number of words minus one (0 = one word).
- `loop_en`  in  1: restart at `base_addr` after the last word instead of finishing.
- `stop`  in  1: pulse; ends a looping or bounded run after in-flight words drain.
- `pace_div`  in  PACE_W: minimum cycles between issued reads minus one.
- `bram_addr`  out  ADDR_W: to BRAM `AddressA`/`AddressB`.
- `bram_clken`  out  1: to BRAM `ClkEn`; high exactly in cycles a read is issued.
- `bram_dout`  in  DATA_W: from BRAM `DataOut`; valid one cycle after issue.
- `m_valid`  out  1: output word valid.
- `m_data`  out  DATA_W: output word.
- `m_ready`  in  1: consumer accepts when `m_valid & m_ready`.
- `busy`  out  1: high from accepted `start` until `done`.
- `done`  out  1: one-cycle pulse when the run completes and the buffer is empty.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN when the last word is issued and `loop_en`=0, or on `stop`.
  - DRAIN→IDLE when there are no in-flight reads and the buffer is empty; `done` pulses on that transition.
- Issue rule (RUN only): a read is issued when the pace counter is 0 and `occupancy + inflight < 2`.
  - `occupancy` is the buffer fill level (0–2); `inflight` is 0 or 1.
- On issue:
  - `bram_clken`=1, `bram_addr`=`base_addr + off`.
  - `off` increments; at `off == last_off` it wraps to 0 when looping.
  - The pace counter reloads to `pace_div`.
- Address arithmetic is modulo 2^ADDR_W: `base_addr + off` wraps past the top of the BRAM.
- The returned word is written into a 2-entry FIFO the cycle after issue. `m_valid` = FIFO not empty; `m_data` = FIFO head.
- `stop` in RUN blocks further issues. Words already issued are still delivered. `stop` in IDLE or DRAIN is ignored.
- `start` while `busy` is ignored, with no side effects.
- Simultaneous `start` and `stop` in IDLE: `start` wins and the run begins.
- `rst` at any time: returns to IDLE, empties the FIFO, clears in-flight state. A read already issued has its returning data discarded.

## Timing
- Reset values: `bram_addr`=0, `bram_clken`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0.
- Latency:
  - `start` at cycle T: first issue at T+1, first `m_valid` at T+2.
  - With `pace_div`=0 and `m_ready` held high, throughput is one word per cycle.
- `busy` rises at T+1.
- `done` is asserted alone, with `busy` still high in the same cycle; `busy` falls the next cycle.
- While `m_valid` is high and `m_ready` is low, `m_data` stays stable and `m_valid` does not drop.

## Configuration
- `BRAM_STREAM_READER_PACE_EN` defined: pace counter present and `pace_div` honoured.
- Undefined:
  - Pace counter removed; `pace_div` is ignored and unconnected.
  - Reads are issued whenever credit permits.

## Structure
- Package `bram_stream_reader_pkg`:
  - state enum (IDLE/RUN/DRAIN);
  - `FIFO_DEPTH`=2;
  - the credit-limit constant.
- Sub-module `bram_stream_skid`: 2-entry FIFO with push, pop, `occupancy`, head data.
- Top-level logic: FSM, offset counter, pace counter, in-flight flag.

## Test plan
- Bounded run: `base_addr`=0x010, `last_off`=3, `pace_div`=0, `m_ready`=1 → `m_data` = ROM[0x010..0x013] on 4 consecutive cycles starting T+2; `done` at T+6.
- Backpressure: `m_ready` low for 5 cycles mid-run → at most 2 words buffered, no issues while full, no loss or duplication; order preserved.
- Address wrap: `base_addr`=0x3FE, `last_off`=3 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Loop then stop: `loop_en`=1, `last_off`=1, `stop` after 5 issues → words follow the sequence A, A+1, A, A+1, A; `done` follows after drain.
- Pacing (macro defined): `pace_div`=3 → `bram_clken` is high every 4th cycle. With the macro undefined, the same stimulus gives back-to-back issues.
- Reset mid-run with an issued read pending → next cycle all outputs are at reset values, and the late BRAM word never appears on `m_data`.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader: FSM states, buffer
// depth and the read-credit limit used to keep the output buffer from overflowing.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH   = 2;
    localparam int CREDIT_LIMIT = FIFO_DEPTH;

    // A new read may only go out if its word is guaranteed a slot in the buffer.
    function automatic logic credit_ok(input logic [1:0] occupancy, input logic inflight);
        return ({1'b0, occupancy} + {2'b00, inflight}) < 3'(CREDIT_LIMIT);
    endfunction

endpackage

// File: rtl/bram_stream_reader_skid.sv
// Two-entry output buffer with fall-through: a word arriving into an empty
// buffer is presented on the head in the same cycle it is pushed.
module bram_stream_skid #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occupancy,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [1:0]        count;
    logic              pop_stored;
    logic              store;

    assign occupancy  = count;
    assign head_valid = (count != 2'd0) || push;
    assign head_data  = (count != 2'd0) ? entry0 : (push ? push_data : '0);

    // A pushed word popped straight through the empty buffer is never stored.
    assign pop_stored = pop && (count != 2'd0);
    assign store      = push && !((count == 2'd0) && pop) && ((count != 2'd2) || pop_stored);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({pop_stored, store})
                2'b10: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        entry0 <= push_data;
                    end else begin
                        entry1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Streaming read controller for a ROM-configured BRAM port: issues a bounded or
// looping address sequence, absorbs the one-cycle read latency and emits a
// valid/ready stream. Define BRAM_STREAM_READER_PACE_EN to enable read pacing.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4,
    parameter int PACE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_off,
    input  logic              loop_en,
    input  logic              stop,
    input  logic [PACE_W-1:0] pace_div,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_clken,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;
    logic [ADDR_W-1:0] off_q;
    logic              inflight;
    logic              issue;
    logic              pace_zero;
    logic [1:0]        occupancy;

`ifdef BRAM_STREAM_READER_PACE_EN
    logic [PACE_W-1:0] pace_cnt;

    // Counter starts at zero for each run so the first read goes out immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pace_cnt <= '0;
        end else if (state == IDLE) begin
            pace_cnt <= '0;
        end else if (issue) begin
            pace_cnt <= pace_div;
        end else if (pace_cnt != '0) begin
            pace_cnt <= pace_cnt - PACE_W'(1);
        end
    end

    assign pace_zero = (pace_cnt == '0);
`else
    logic unused_pace;

    assign unused_pace = ^pace_div;
    assign pace_zero   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = DRAIN;
                end else if (pace_zero && credit_ok(occupancy, inflight)) begin
                    issue = 1'b1;
                    if ((off_q == last_q) && !loop_q) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight && (occupancy == 2'd0)) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Run parameters are captured only from IDLE so a start during a run has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            off_q    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if ((state == IDLE) && start) begin
                base_q <= base_addr;
                last_q <= last_off;
                loop_q <= loop_en;
                off_q  <= '0;
            end else if (issue) begin
                off_q <= (off_q == last_q) ? '0 : off_q + ADDR_W'(1);
            end
        end
    end

    assign bram_addr  = base_q + off_q;
    assign bram_clken = issue;
    assign busy       = (state != IDLE);

    bram_stream_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (bram_dout),
        .pop        (m_valid && m_ready),
        .occupancy  (occupancy),
        .head_valid (m_valid),
        .head_data  (m_data)
    );

endmodule
